// File: rtl/stream_arb_2to1.sv
// Two-input round-robin stream arbiter feeding a single registered output slot.
// y_src tells a downstream consumer which source the held word came from.
module stream_arb_2to1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             y_src
);

  // Handshake: a word moves on a channel at a rising edge where its valid and
  // ready are both high; valid never waits on ready, ready is combinational.

  logic last_grant;
  logic load_en;
  logic grant_a;
  logic grant_b;
  logic take_a;
  logic take_b;

  // The output slot can accept a word when empty or draining this cycle.
  assign load_en = !y_valid | y_ready;

  // On a tie the source not granted last wins; last_grant = 1 means B went last.
  assign grant_a = a_valid & (!b_valid | last_grant);
  assign grant_b = b_valid & (!a_valid | !last_grant);

  assign a_ready = load_en & grant_a & !rst;
  assign b_ready = load_en & grant_b & !rst;

  assign take_a = a_ready & a_valid;
  assign take_b = b_ready & b_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid    <= 1'b0;
      y_data     <= '0;
      y_src      <= 1'b0;
      last_grant <= 1'b1;
    end else if (take_a) begin
      y_valid    <= 1'b1;
      y_data     <= a_data;
      y_src      <= 1'b0;
      last_grant <= 1'b0;
    end else if (take_b) begin
      y_valid    <= 1'b1;
      y_data     <= b_data;
      y_src      <= 1'b1;
      last_grant <= 1'b1;
    end else if (y_valid && y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule
